assoc_cache: RTL and testbench

Parametrised N-way set-associative write-back, write-allocate cache with per-byte write enables, valid/dirty bits per way and round-robin replacement. It sits between the core's load/store path (word addressed, `stall`-based backpressure) and line-wide main memory. Memory transfers use separate read and write line buses with a level `mem_ready` handshake, so no tristate bus is involved.

---
 rtl/cache_pkg.sv | 7 +
 rtl/cache_victim_sel.sv | 22 ++
 rtl/assoc_cache.sv | 143 ++++++++++++++
 tb/tb_assoc_cache.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// cache_pkg: FSM state type and way-index width helper shared by the cache files.
package cache_pkg;
  typedef enum logic [1:0] {C_IDLE, C_WB, C_FILL} cache_state_e;
  function automatic int way_bits(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction
endpackage

// File: rtl/cache_victim_sel.sv
// cache_victim_sel: picks the lowest invalid way of a set, falling back to the round-robin pointer.
module cache_victim_sel
  import cache_pkg::*;
#(
  parameter int WAYS = 2,
  parameter int WB = way_bits(WAYS)
) (
  input  logic [WAYS-1:0] valid_i,
  input  logic [WB-1:0]   rr_i,
  output logic [WB-1:0]   victim_o,
  output logic            from_rr_o
);
  always_comb begin
    victim_o = rr_i;
    from_rr_o = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid_i[w]) begin
        victim_o = WB'(w);
        from_rr_o = 1'b0;
      end
  end
endmodule

// File: rtl/assoc_cache.sv
// assoc_cache: N-way set-associative write-back, write-allocate cache with
// per-byte write enables and round-robin replacement.
module assoc_cache
  import cache_pkg::*;
#(
  parameter int ADDR_SIZE = 30,
  parameter int WORD_SIZE = 32,
  parameter int BLOCK_OFFSET_BITS = 2,
  parameter int INDEX_BITS = 4,
  parameter int WAYS = 2
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          req,
  input  logic                                          we,
  input  logic [WORD_SIZE/8-1:0]                        be,
  input  logic [ADDR_SIZE-1:0]                          addr,
  input  logic [WORD_SIZE-1:0]                          data_w,
  output logic [WORD_SIZE-1:0]                          data_r,
  output logic                                          stall,
  output logic [ADDR_SIZE-BLOCK_OFFSET_BITS-1:0]        mem_addr,
  output logic                                          mem_r,
  output logic                                          mem_w,
  output logic [(WORD_SIZE<<BLOCK_OFFSET_BITS)-1:0]     mem_wdata,
  input  logic [(WORD_SIZE<<BLOCK_OFFSET_BITS)-1:0]     mem_rdata,
  input  logic                                          mem_ready
);
  localparam int TAG_BITS = ADDR_SIZE - BLOCK_OFFSET_BITS - INDEX_BITS;
  localparam int LINE_BITS = WORD_SIZE << BLOCK_OFFSET_BITS;
  localparam int LA = ADDR_SIZE - BLOCK_OFFSET_BITS;
  localparam int SETS = 1 << INDEX_BITS;
  localparam int WB = way_bits(WAYS);
  localparam int BYTES = WORD_SIZE / 8;

  logic [LINE_BITS-1:0] data_q [SETS][WAYS];
  logic [TAG_BITS-1:0]  tag_q [SETS][WAYS];
  logic [WAYS-1:0]      valid_q [SETS];
  logic [WAYS-1:0]      dirty_q [SETS];
  logic [WB-1:0]        rr_q [SETS];
  cache_state_e         state_q, state_d;
  logic                 mem_r_d, mem_w_d;
  logic [LA-1:0]        mem_addr_d;
  logic [WB-1:0]        victim_q, victim_d, sel_way, hit_way;
  logic                 from_rr_q, from_rr_d, sel_rr, hit, need_wb;
  logic                 miss, wr_hit, wb_done, fill_done;
  logic [TAG_BITS-1:0]  tag;
  logic [INDEX_BITS-1:0] idx;
  logic [BLOCK_OFFSET_BITS-1:0] off;

  assign tag = addr[ADDR_SIZE-1 -: TAG_BITS];
  assign idx = addr[BLOCK_OFFSET_BITS +: INDEX_BITS];
  assign off = addr[BLOCK_OFFSET_BITS-1:0];

  cache_victim_sel #(.WAYS(WAYS), .WB(WB)) u_victim (
    .valid_i  (valid_q[idx]),
    .rr_i     (rr_q[idx]),
    .victim_o (sel_way),
    .from_rr_o(sel_rr)
  );

  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
        hit = 1'b1;
        hit_way = WB'(w);
      end
  end

  assign data_r    = data_q[idx][hit_way][off*WORD_SIZE +: WORD_SIZE];
  // Victim is latched on the miss, so the write-back line stays fixed through C_WB.
  assign mem_wdata = data_q[idx][victim_q];
  assign stall     = (state_q != C_IDLE) | (req & ~hit);
  assign need_wb   = valid_q[idx][sel_way] & dirty_q[idx][sel_way];
  assign miss      = (state_q == C_IDLE) & req & ~hit;
  assign wr_hit    = (state_q == C_IDLE) & req & we & hit;
  assign wb_done   = (state_q == C_WB) & mem_ready;
  assign fill_done = (state_q == C_FILL) & mem_ready;

  always_comb begin
    state_d = state_q;
    mem_r_d = mem_r;
    mem_w_d = mem_w;
    mem_addr_d = mem_addr;
    victim_d = victim_q;
    from_rr_d = from_rr_q;
    if (miss) begin
      victim_d = sel_way;
      from_rr_d = sel_rr;
      state_d = need_wb ? C_WB : C_FILL;
      mem_w_d = need_wb;
      mem_r_d = ~need_wb;
      mem_addr_d = need_wb ? {tag_q[idx][sel_way], idx} : addr[ADDR_SIZE-1:BLOCK_OFFSET_BITS];
    end else if (wb_done) begin
      state_d = C_FILL;
      mem_w_d = 1'b0;
      mem_r_d = 1'b1;
      mem_addr_d = addr[ADDR_SIZE-1:BLOCK_OFFSET_BITS];
    end else if (fill_done) begin
      state_d = C_IDLE;
      mem_r_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= C_IDLE;
      mem_r <= 1'b0;
      mem_w <= 1'b0;
      mem_addr <= '0;
      victim_q <= '0;
      from_rr_q <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        rr_q[s] <= '0;
      end
    end else begin
      state_q <= state_d;
      mem_r <= mem_r_d;
      mem_w <= mem_w_d;
      mem_addr <= mem_addr_d;
      victim_q <= victim_d;
      from_rr_q <= from_rr_d;
      if (wr_hit && |be) dirty_q[idx][hit_way] <= 1'b1;
      if (wb_done) dirty_q[idx][victim_q] <= 1'b0;
      if (fill_done) begin
        valid_q[idx][victim_q] <= 1'b1;
        dirty_q[idx][victim_q] <= 1'b0;
        if (from_rr_q && WAYS > 1) rr_q[idx] <= rr_q[idx] + 1'b1;
      end
    end

  always_ff @(posedge clk) begin
    if (fill_done) begin
      data_q[idx][victim_q] <= mem_rdata;
      tag_q[idx][victim_q] <= tag;
    end
    for (int b = 0; b < BYTES; b++)
      if (wr_hit && be[b]) data_q[idx][hit_way][off*WORD_SIZE + b*8 +: 8] <= data_w[b*8 +: 8];
  end
endmodule

// File: tb/tb_assoc_cache.sv
// tb_assoc_cache: scoreboard-driven bench for assoc_cache with a latency-programmable memory responder.
module tb_assoc_cache;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req = 1'b0, we = 1'b0;
  logic [3:0]   be = '0;
  logic [29:0]  addr = '0;
  logic [31:0]  data_w = '0;
  logic [31:0]  data_r;
  logic         stall;
  logic [27:0]  mem_addr;
  logic         mem_r, mem_w;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata = '0;
  logic         mem_ready = 1'b0;

  int checks = 0, failures = 0;
  int n_rd = 0, n_wr = 0, lat = 0, wcnt = 0;
  logic [31:0]  exp_q[$];
  logic [127:0] mem_model [logic [27:0]];

  assoc_cache dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .be(be), .addr(addr),
    .data_w(data_w), .data_r(data_r), .stall(stall), .mem_addr(mem_addr),
    .mem_r(mem_r), .mem_w(mem_w), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] dflt(input logic [27:0] la);
    logic [127:0] l;
    if (la == 28'h4) return 128'h44444444_33333333_22222222_11111111;
    if (la == 28'h14) return 128'h88888888_77777777_66666666_55555555;
    for (int w = 0; w < 4; w++) l[w*32 +: 32] = 32'hC0000000 | ({4'h0, la} << 8) | w;
    return l;
  endfunction

  function automatic logic [31:0] word_of(input logic [29:0] a);
    logic [127:0] l;
    l = mem_model.exists(a[29:2]) ? mem_model[a[29:2]] : dflt(a[29:2]);
    return l[a[1:0]*32 +: 32];
  endfunction

  // Memory responder: after lat waiting cycles, pulses mem_ready for one cycle.
  always @(negedge clk) begin
    if (mem_ready) mem_ready = 1'b0;
    else if (mem_r || mem_w) begin
      if (wcnt < lat) wcnt++;
      else begin
        wcnt = 0;
        mem_ready = 1'b1;
        if (mem_w) begin mem_model[mem_addr] = mem_wdata; n_wr++; end
        else begin mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : dflt(mem_addr); n_rd++; end
      end
    end else wcnt = 0;
  end

  task automatic rd(input logic [29:0] a, input logic [31:0] exp, output int stalls);
    logic [31:0] e;
    exp_q.push_back(exp);
    req = 1'b1; we = 1'b0; be = '0; addr = a;
    #1;
    stalls = 0;
    while (stall && stalls < 200) begin @(negedge clk); #1; stalls++; end
    e = exp_q.pop_front();
    checks++;
    if (stall) begin failures++; $display("FAIL rd_timeout addr=%h", a); end
    else if (data_r !== e) begin failures++; $display("FAIL rd_data addr=%h got=%h exp=%h", a, data_r, e); end
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wr(input logic [29:0] a, input logic [3:0] b, input logic [31:0] d);
    int n = 0;
    req = 1'b1; we = 1'b1; addr = a; be = b; data_w = d;
    #1;
    while (stall && n < 200) begin @(negedge clk); #1; n++; end
    checks++;
    if (stall) begin failures++; $display("FAIL wr_timeout addr=%h", a); end
    @(negedge clk);
    req = 1'b0; we = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0 || mem_r !== 1'b0 || mem_w !== 1'b0 || mem_addr !== 28'h0) begin
      failures++;
      $display("FAIL reset_idle stall=%b mem_r=%b mem_w=%b mem_addr=%h exp 0 0 0 0", stall, mem_r, mem_w, mem_addr);
    end
    req = 1'b1; addr = 30'h10;
    #1;
    checks++;
    if (stall !== 1'b1) begin failures++; $display("FAIL reset_stall got=%b exp=1", stall); end
    req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_cold_read;
    logic [31:0] e;
    exp_q.push_back(32'h11111111);
    req = 1'b1; we = 1'b0; addr = 30'h10;
    #1;
    checks++;
    if (stall !== 1'b1 || mem_r !== 1'b0) begin failures++; $display("FAIL cold_cycle0 stall=%b mem_r=%b exp 1 0", stall, mem_r); end
    @(negedge clk); #1;
    checks++;
    if (mem_r !== 1'b1 || mem_w !== 1'b0 || mem_addr !== 28'h4) begin
      failures++; $display("FAIL cold_cycle1 mem_r=%b mem_w=%b mem_addr=%h exp 1 0 004", mem_r, mem_w, mem_addr);
    end
    @(negedge clk); #1;
    e = exp_q.pop_front();
    checks++;
    if (stall !== 1'b0 || data_r !== e) begin failures++; $display("FAIL cold_data stall=%b data=%h exp 0 %h", stall, data_r, e); end
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic test_byte_write;
    int s, t;
    t = n_rd + n_wr;
    wr(30'h10, 4'b0011, 32'hAABBCCDD);
    rd(30'h10, 32'h1111CCDD, s);
    checks++;
    if (s != 0 || n_rd + n_wr != t) begin failures++; $display("FAIL byte_write_hit stalls=%0d traffic=%0d exp 0 %0d", s, n_rd + n_wr, t); end
  endtask

  task automatic test_assoc;
    int s, t;
    rd(30'h50, 32'h55555555, s);
    checks++;
    if (s == 0) begin failures++; $display("FAIL assoc_fill stalls=%0d exp >0", s); end
    t = n_rd + n_wr;
    for (int i = 0; i < 3; i++) begin
      rd(30'h10, 32'h1111CCDD, s);
      checks++;
      if (s != 0) begin failures++; $display("FAIL assoc_hit0 stalls=%0d exp 0", s); end
      rd(30'h51, 32'h66666666, s);
      checks++;
      if (s != 0) begin failures++; $display("FAIL assoc_hit1 stalls=%0d exp 0", s); end
    end
    checks++;
    if (n_rd + n_wr != t) begin failures++; $display("FAIL assoc_traffic got=%0d exp=%0d", n_rd + n_wr, t); end
  endtask

  task automatic test_write_allocate;
    int s;
    wr(30'h60, 4'hF, 32'h12345678);
    rd(30'h60, 32'h12345678, s);
    rd(30'h61, word_of(30'h61), s);
  endtask

  task automatic test_dirty_evict;
    logic [31:0] e;
    logic [127:0] wd;
    logic [27:0] ma;
    int n, w0;
    lat = 12;
    w0 = n_wr;
    exp_q.push_back(word_of(30'h90));
    req = 1'b1; we = 1'b0; addr = 30'h90;
    @(negedge clk); #1;
    wd = mem_wdata; ma = mem_addr;
    checks++;
    if (mem_w !== 1'b1 || mem_r !== 1'b0 || ma !== 28'h4 || wd !== 128'h44444444_33333333_22222222_1111CCDD) begin
      failures++; $display("FAIL evict_wb mem_w=%b mem_r=%b addr=%h wdata=%h", mem_w, mem_r, ma, wd);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      checks++;
      if (stall !== 1'b1 || mem_w !== 1'b1 || mem_r !== 1'b0 || mem_addr !== ma || mem_wdata !== wd) begin
        failures++; $display("FAIL backpressure_hold cyc=%0d stall=%b mem_w=%b mem_r=%b addr=%h", i, stall, mem_w, mem_r, mem_addr);
      end
    end
    lat = 0;
    n = 0;
    while (!mem_r && n < 50) begin @(negedge clk); #1; n++; end
    checks++;
    if (mem_r !== 1'b1 || mem_w !== 1'b0 || mem_addr !== 28'h24) begin
      failures++; $display("FAIL evict_fill mem_r=%b mem_w=%b addr=%h exp 1 0 024", mem_r, mem_w, mem_addr);
    end
    n = 0;
    while (stall && n < 50) begin @(negedge clk); #1; n++; end
    e = exp_q.pop_front();
    checks++;
    if (stall !== 1'b0 || data_r !== e) begin failures++; $display("FAIL evict_data stall=%b data=%h exp 0 %h", stall, data_r, e); end
    @(negedge clk);
    req = 1'b0;
    checks++;
    if (n_wr != w0 + 1) begin failures++; $display("FAIL evict_wb_count got=%0d exp=%0d", n_wr, w0 + 1); end
    rd(30'h10, 32'h1111CCDD, n);
    checks++;
    if (n == 0) begin failures++; $display("FAIL reread_miss stalls=%0d exp >0", n); end
    rd(30'hD0, word_of(30'hD0), n);
    rd(30'h110, word_of(30'h110), n);
    wr(30'h110, 4'b0000, 32'hFFFFFFFF);
    rd(30'h150, word_of(30'h150), n);
    rd(30'h190, word_of(30'h190), n);
    checks++;
    if (n_wr != w0 + 1) begin failures++; $display("FAIL clean_evictions wb_count=%0d exp=%0d", n_wr, w0 + 1); end
  endtask

  task automatic test_reset_mid_fill;
    int s;
    lat = 50;
    req = 1'b1; we = 1'b0; addr = 30'h200;
    @(negedge clk); #1;
    checks++;
    if (mem_r !== 1'b1) begin failures++; $display("FAIL midfill_req mem_r=%b exp 1", mem_r); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (mem_r !== 1'b0 || mem_w !== 1'b0 || mem_addr !== 28'h0) begin
      failures++; $display("FAIL async_reset mem_r=%b mem_w=%b addr=%h exp 0 0 0", mem_r, mem_w, mem_addr);
    end
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    lat = 0;
    @(negedge clk);
    rd(30'h10, 32'h1111CCDD, s);
    checks++;
    if (s == 0) begin failures++; $display("FAIL post_reset_miss stalls=%0d exp >0", s); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_cold_read();
    test_byte_write();
    test_assoc();
    test_write_allocate();
    test_dirty_evict();
    test_reset_mid_fill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
